// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: mode values, FSM states and per-mode seeds.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_R  = 2'd0;
    localparam logic [1:0] MODE_ROT_L  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } state_e;

    localparam logic [15:0] SEED_ROT_R  = 16'h8000;
    localparam logic [15:0] SEED_ROT_L  = 16'h0001;
    localparam logic [15:0] SEED_BOUNCE = 16'h8000;
    localparam logic [15:0] SEED_FILL   = 16'h8000;

    function automatic logic [15:0] mode_seed(input logic [1:0] m);
        logic [15:0] s;
        unique case (m)
            MODE_ROT_R:  s = SEED_ROT_R;
            MODE_ROT_L:  s = SEED_ROT_L;
            MODE_BOUNCE: s = SEED_BOUNCE;
            MODE_FILL:   s = SEED_FILL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// Step prescaler: counts 0..(BASE_COUNT >> speed)-1 while running and flags the wrap cycle.
module step_prescaler #(
    parameter int unsigned      CNT_W      = 26,
    parameter logic [CNT_W-1:0] BASE_COUNT = 26'h3FFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_m1;
    logic [1:0]       speed_q;
    logic             speed_chg;

    assign speed_chg = (speed != speed_q);
    assign period_m1 = (BASE_COUNT >> speed_q) - CntOne;

    // A speed change restarts the period and suppresses any tick due this cycle.
    assign tick = run && !clear && !speed_chg && (cnt_q == period_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || speed_chg) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            speed_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Sequences a 16-LED pattern (rotate right/left, bounce, fill bar) at a speed-selectable step rate.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned      CNT_W      = 26,
    parameter logic [CNT_W-1:0] BASE_COUNT = 26'h3FFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pause,
    input  logic        mode_step,
    input  logic [1:0]  speed,
    output logic [15:0] dataOut,
    output logic [1:0]  mode,
    output logic        step_tick,
    output logic        running
);

    localparam logic DirRight = 1'b0;
    localparam logic DirLeft  = 1'b1;

    state_e      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  mode_q, mode_d;
    logic        dir_q, dir_d;
    logic        tick_q;
    logic        run, clear, tick;

    // Counting also happens on the PAUSED->RUN edge so a resumed count picks up immediately.
    assign run   = en && !pause && (state_q != StIdle);
    assign clear = mode_step || !en || (state_q == StIdle);

    step_prescaler #(
        .CNT_W     (CNT_W),
        .BASE_COUNT(BASE_COUNT)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clear(clear),
        .speed(speed),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (en) state_d = StRun;
            StRun: begin
                if (!en)        state_d = StIdle;
                else if (pause) state_d = StPaused;
            end
            StPaused: begin
                if (!en)         state_d = StIdle;
                else if (!pause) state_d = StRun;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (mode_step) begin
            mode_d = mode_q + 2'd1;
            data_d = mode_seed(mode_d);
            dir_d  = DirRight;
        end else if (!en) begin
            data_d = mode_seed(mode_q);
            dir_d  = DirRight;
        end else if (tick) begin
            unique case (mode_q)
                MODE_ROT_R:  data_d = {data_q[0], data_q[15:1]};
                MODE_ROT_L:  data_d = {data_q[14:0], data_q[15]};
                MODE_BOUNCE: begin
                    // Flip on arrival at an endpoint so each endpoint is shown exactly once.
                    if (dir_q == DirRight) begin
                        data_d = data_q >> 1;
                        if (data_d == 16'h0001) dir_d = DirLeft;
                    end else begin
                        data_d = data_q << 1;
                        if (data_d == 16'h8000) dir_d = DirRight;
                    end
                end
                MODE_FILL: begin
                    if (data_q == 16'hFFFF)      data_d = 16'h0000;
                    else if (data_q == 16'h0000) data_d = 16'h8000;
                    else                         data_d = {1'b1, data_q[15:1]};
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= SEED_ROT_R;
            mode_q  <= MODE_ROT_R;
            dir_q   <= DirRight;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            tick_q  <= tick;
        end
    end

    assign dataOut   = data_q;
    assign mode      = mode_q;
    assign step_tick = tick_q;
    assign running   = (state_q == StRun);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised scoreboard bench for led_pattern_sequencer with BASE_COUNT = 8.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pause = 1'b0;
    logic        mode_step = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [15:0] dataOut;
    logic [1:0]  mode;
    logic        step_tick;
    logic        running;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .CNT_W     (26),
        .BASE_COUNT(26'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pause    (pause),
        .mode_step(mode_step),
        .speed    (speed),
        .dataOut  (dataOut),
        .mode     (mode),
        .step_tick(step_tick),
        .running  (running)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pattern sequences indexed by step number since the seed.
    function automatic int pat_len(input int md);
        case (md)
            2:       return 30;
            3:       return 17;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] pat(input int md, input int k);
        logic [15:0] ones;
        ones = 16'hFFFF;
        case (md)
            0: return 16'h8000 >> k;
            1: return 16'h0001 << k;
            2: return 16'h0001 << ((k <= 15) ? (15 - k) : (k - 15));
            default: begin
                if (k == 16) return 16'h0000;
                return ~(ones >> (k + 1));
            end
        endcase
    endfunction

    // Reference model
    int          m_mode, m_k, m_cnt, p;
    logic [1:0]  m_speed;
    bit          m_active, m_run, m_tick, was_active, chg;
    logic [15:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_k = 0; m_cnt = 0; m_speed = 2'd0;
            m_active = 0; m_run = 0; m_tick = 0;
            exp_q.delete();
        end else begin
            was_active = m_active;
            chg        = (speed != m_speed);
            p          = 8 >> m_speed;
            m_tick     = 0;
            if (mode_step) begin
                m_mode = (m_mode + 1) % 4;
                m_k = 0;
                m_cnt = 0;
            end else if (!en) begin
                m_k = 0;
                m_cnt = 0;
            end else if (chg) begin
                m_cnt = 0;
            end else if (was_active && !pause) begin
                m_cnt++;
                if (m_cnt == p) begin
                    m_cnt  = 0;
                    m_k    = (m_k + 1) % pat_len(m_mode);
                    m_tick = 1;
                    exp_q.push_back(pat(m_mode, m_k));
                end
            end
            m_speed  = speed;
            m_active = en;
            m_run    = en && (!was_active || !pause);
        end
    end

    // Monitor
    logic [15:0] popped;
    always @(negedge clk) begin
        chk("dataOut", {16'h0, dataOut}, {16'h0, pat(m_mode, m_k)});
        chk("mode", {30'h0, mode}, m_mode);
        chk("running", {31'h0, running}, {31'h0, m_run});
        chk("step_tick", {31'h0, step_tick}, {31'h0, m_tick});
        if (step_tick) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL step_pop: step_tick with nothing expected at %0t", $time);
            end else begin
                popped = exp_q.pop_front();
                chk("step_pop", {16'h0, dataOut}, {16'h0, popped});
            end
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_step();
        @(negedge clk);
        mode_step = 1'b1;
        @(negedge clk);
        mode_step = 1'b0;
    endtask

    initial begin
        bit hit;
        run_cycles(3);
        rst = 1'b0;
        run_cycles(2);

        en = 1'b1; run_cycles(140);
        en = 1'b0; pulse_step(); en = 1'b1; run_cycles(140);
        pulse_step(); run_cycles(250);
        pulse_step(); run_cycles(150);
        pulse_step(); run_cycles(3);
        chk("mode_wrap", {30'h0, mode}, 32'd0);

        // Pause at count 5, resume, then drop en while paused.
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (m_run && m_cnt == 5) hit = 1;
        end
        chk("reach_cnt5", {31'h0, hit}, 32'd1);
        pause = 1'b1; run_cycles(20);
        pause = 1'b0; run_cycles(5);
        pause = 1'b1; run_cycles(3);
        en = 1'b0; run_cycles(2);
        chk("idle_seed", {16'h0, dataOut}, 32'h8000);
        pause = 1'b0; en = 1'b1;

        speed = 2'd2; run_cycles(21);
        speed = 2'd0; run_cycles(20);

        // mode_step on the cycle a tick is due.
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (m_active && en && !pause && speed == m_speed && m_cnt == 7) begin
                mode_step = 1'b1;
                hit = 1;
                @(negedge clk);
                mode_step = 1'b0;
            end
        end
        chk("coincide_found", {31'h0, hit}, 32'd1);
        run_cycles(12);

        // Asynchronous reset mid-run, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("async_data", {16'h0, dataOut}, 32'h8000);
        chk("async_mode", {30'h0, mode}, 32'd0);
        chk("async_run", {30'h0, running, step_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            mode_step = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) en = !en;
            if ($urandom_range(0, 24) == 0) pause = !pause;
            if ($urandom_range(0, 79) == 0) speed = 2'($urandom_range(0, 2));
        end
        mode_step = 1'b0;
        run_cycles(2);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that sequences the 16-LED display pattern. It owns a speed-selectable step prescaler and a mode register, and generates the 16-bit LED word for four patterns: rotate right, rotate left, bounce, and fill bar. Board-level logic drives its run, pause, mode-step and speed controls, and `dataOut` drives the LEDs directly.

Parameters:
CNT_W, 26, prescaler counter width.
BASE_COUNT, 26'h3FFFFFF, step period in clocks at `speed`=0. Effective period = BASE_COUNT >> speed; minimum legal effective period is 2.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  level; 1 = run sequence, 0 = idle with seed shown.
pause  input  1  level; freezes prescaler and pattern while running.
mode_step  input  1  single-cycle pulse, already synchronised; advances mode.
speed  input  2  period select, 0 = slowest, 3 = fastest.
dataOut  output  16  LED pattern, registered.
mode  output  2  current mode, registered: 0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 FILL.
step_tick  output  1  registered one-cycle pulse, high in the cycle `dataOut` shows a newly stepped value.
running  output  1  1 when FSM is in RUN.

Behaviour:
- Reset (async, immediate) values:
  - dataOut = 16'h8000, mode = 0, step_tick = 0, running = 0.
  - FSM = IDLE, prescaler = 0, bounce direction = right, registered speed copy = 0.
- Seeds per mode:
  - ROT_R 16'h8000; ROT_L 16'h0001; BOUNCE 16'h8000 with direction right; FILL 16'h8000.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE: dataOut = seed of current mode, prescaler held at 0. `en`=1 -> RUN on next edge.
  - RUN:
    - `en`=0 -> IDLE: reload seed, clear prescaler.
    - else `pause`=1 -> PAUSED.
    - else count.
  - PAUSED: prescaler and dataOut frozen.
    - `en`=0 -> IDLE: reload seed, clear prescaler.
    - `pause`=0 -> RUN, resuming the count from its frozen value.
  - Priority: `en`=0 overrides `pause`.
- Prescaler (RUN only):
  - Counts 0..P-1, where P = BASE_COUNT >> speed.
  - At count P-1: internal tick; counter returns to 0 on the same edge.
  - Pattern step and step_tick are registered on that edge.
  - First step occurs P cycles after entering RUN.
- Speed change: when `speed` differs from the registered copy, the prescaler clears to 0 and the copy updates. No tick is issued that cycle. The pattern is unchanged.
- Step rules (on tick):
  - ROT_R: logical shift right; 16'h0001 wraps to 16'h8000.
  - ROT_L: logical shift left; 16'h8000 wraps to 16'h0001.
  - BOUNCE: shift in the current direction. Direction flips to left on reaching 16'h0001 and to right on reaching 16'h8000. The endpoint is shown once, with no double dwell. Sequence: 8000, 4000, ..., 0001, 0002, ..., 8000, 4000, ...
  - FILL: next = {1'b1, dataOut[15:1]} until 16'hFFFF. 16'hFFFF -> 16'h0000, and 16'h0000 -> 16'h8000.
- `mode_step` (accepted in any state):
  - mode <= mode+1 mod 4 (3 wraps to 0).
  - dataOut <= seed of the new mode; prescaler <= 0; direction <= right.
  - FSM state is unchanged.
  - If it coincides with a tick, `mode_step` wins: no step and no step_tick.
- `dataOut` is always one-hot in ROT/BOUNCE modes. It is never 0 except FILL's blank step.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package led_seq_pkg holds:
  - mode encoding constants: MODE_ROT_R=0, MODE_ROT_L=1, MODE_BOUNCE=2, MODE_FILL=3.
  - FSM state encoding: IDLE, RUN, PAUSED.
  - seed constants SEED_ROT_R, SEED_ROT_L, SEED_BOUNCE, SEED_FILL.
- One natural sub-module: step_prescaler.
  - Inputs: clk, rst, run, clear, speed. Output: tick.
  - Holds the counter and the speed-change clear logic.
  - Parameterised by CNT_W and BASE_COUNT.

Test Plan:
- All tests use BASE_COUNT=8, speed=0 (P=8) unless noted.
1. Reset then en=1, mode 0 -> dataOut 8000, 4000, 2000, ..., 0001, then 8000, with a step every 8 cycles. step_tick is high for one cycle per step. First step comes 8 cycles after running rises.
2. `mode_step` pulse from reset, then en=1 (ROT_L) -> 0001, 0002, ..., 8000, 0001. A second `mode_step` (BOUNCE) -> 8000 ... 0001, 0002 ... 8000, with each endpoint appearing once.
3. Three `mode_step` pulses (FILL), en=1 -> 8000, C000, E000, ..., FFFF, 0000, 8000. A fourth pulse -> mode=0, dataOut=8000.
4. RUN at prescaler count 5: pause=1 for 20 cycles -> dataOut and step_tick frozen. After pause=0, the next step arrives 3 cycles later. en=0 during PAUSED -> IDLE, dataOut = seed.
5. speed=2 (P=2) -> a step every 2 cycles. Switching speed to 0 mid-count -> prescaler clears, and the next step comes 8 cycles after the change.
6. `mode_step` coincident with a tick -> new seed shown, no step_tick. Assert rst mid-RUN -> outputs take reset values immediately, without waiting for a clock edge.
